// File: rtl/guess_entry_ctrl.sv
// ---------------------------------------------------------------------------
// guess_entry_ctrl
//   Game-flow controller for a shape-pattern guessing game. Handles credit
//   consumption at game start, loading of the master pattern slot by slot,
//   guess submission with grade handshakes, round counting and win/lose
//   end-of-game flags.
//
// Ports
//   clock        in   single clock, all state on its rising edge
//   reset_n      in   asynchronous active-low reset
//   start_game   in   synchronized start request (level)
//   credit_ok    in   at least one paid game is available
//   key          in   synchronized action button (level, high = pressed)
//   slot         in   target slot for a master-shape load
//   clear_game   in   synchronous abort back to IDLE (highest priority)
//   grade_done   in   grader result valid (one-cycle pulse)
//   win          in   grader verdict, qualified by grade_done
//   load_en      out  one-hot master-slot write strobe (one cycle)
//   slot_loaded  out  per-slot loaded flags
//   load_guess   out  high while guesses are accepted (PLAY)
//   grade_req    out  one-cycle grade request pulse
//   game_start   out  one-cycle pulse consuming one credit
//   round_number out  guesses submitted this game
//   game_over    out  game finished
//   game_won     out  game finished with a correct guess
// ---------------------------------------------------------------------------
module guess_entry_ctrl #(
   parameter int NUM_SLOTS  = 4,
   parameter int SHAPE_W    = 3,
   parameter int MAX_ROUNDS = 8,
   localparam int SLOT_W    = $clog2(NUM_SLOTS),
   localparam int RND_W     = $clog2(MAX_ROUNDS + 1)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start_game,
   input  logic                 credit_ok,
   input  logic                 key,
   input  logic [SLOT_W-1:0]    slot,
   input  logic                 clear_game,
   input  logic                 grade_done,
   input  logic                 win,
   output logic [NUM_SLOTS-1:0] load_en,
   output logic [NUM_SLOTS-1:0] slot_loaded,
   output logic                 load_guess,
   output logic                 grade_req,
   output logic                 game_start,
   output logic [RND_W-1:0]     round_number,
   output logic                 game_over,
   output logic                 game_won
);

   // Reject unsupported configurations at elaboration time.
   if (SHAPE_W < 1 || NUM_SLOTS < 2 || NUM_SLOTS > 8 ||
       MAX_ROUNDS < 1 || MAX_ROUNDS > 15) begin : g_bad_params
      $error("guess_entry_ctrl: unsupported parameter set");
   end

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_GWAIT = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;

   logic [2:0]           r_state;
   logic                 r_key_q;
   logic [NUM_SLOTS-1:0] r_load_en;
   logic [NUM_SLOTS-1:0] r_slot_loaded;
   logic                 r_grade_req;
   logic                 r_game_start;
   logic [RND_W-1:0]     r_round;
   logic                 r_game_over;
   logic                 r_game_won;

   logic                 w_key_edge;
   logic                 w_slot_ok;
   logic                 w_start_ok;
   logic                 w_last_round;
   logic [NUM_SLOTS-1:0] w_slot_onehot;

   assign w_key_edge    = key & ~r_key_q;
   assign w_slot_ok     = ({1'b0, slot} < NUM_SLOTS[SLOT_W:0]);
   assign w_start_ok    = start_game & credit_ok;
   assign w_last_round  = (r_round == RND_W'(MAX_ROUNDS));
   assign w_slot_onehot = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot;

   // key_q resets high so a button held through reset release is not an edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_key_q <= 1'b1;
      else          r_key_q <= key;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_load_en     <= '0;
         r_slot_loaded <= '0;
         r_grade_req   <= 1'b0;
         r_game_start  <= 1'b0;
         r_round       <= '0;
         r_game_over   <= 1'b0;
         r_game_won    <= 1'b0;
      end else if (clear_game) begin
         r_state       <= S_IDLE;
         r_load_en     <= '0;
         r_slot_loaded <= '0;
         r_grade_req   <= 1'b0;
         r_game_start  <= 1'b0;
         r_round       <= '0;
         r_game_over   <= 1'b0;
         r_game_won    <= 1'b0;
      end else begin
         // Strobes are single-cycle by default.
         r_load_en    <= '0;
         r_grade_req  <= 1'b0;
         r_game_start <= 1'b0;
         case (r_state)
            S_IDLE, S_OVER: begin
               if (w_start_ok) begin
                  r_state       <= S_SETUP;
                  r_game_start  <= 1'b1;
                  r_slot_loaded <= '0;
                  r_round       <= '0;
                  r_game_over   <= 1'b0;
                  r_game_won    <= 1'b0;
               end
            end
            S_SETUP: begin
               // Leave one cycle after the last slot flag is set.
               if (&r_slot_loaded) begin
                  r_state <= S_PLAY;
               end else if (w_key_edge && w_slot_ok) begin
                  r_load_en     <= w_slot_onehot;
                  r_slot_loaded <= r_slot_loaded | w_slot_onehot;
               end
            end
            S_PLAY: begin
               if (w_key_edge && !w_last_round) begin
                  r_grade_req <= 1'b1;
                  r_round     <= r_round + 1'b1;
                  r_state     <= S_GWAIT;
               end
            end
            S_GWAIT: begin
               if (grade_done) begin
                  if (win) begin
                     r_game_won  <= 1'b1;
                     r_game_over <= 1'b1;
                     r_state     <= S_OVER;
                  end else if (w_last_round) begin
                     r_game_over <= 1'b1;
                     r_state     <= S_OVER;
                  end else begin
                     r_state <= S_PLAY;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign load_en      = r_load_en;
   assign slot_loaded  = r_slot_loaded;
   assign load_guess   = (r_state == S_PLAY);
   assign grade_req    = r_grade_req;
   assign game_start   = r_game_start;
   assign round_number = r_round;
   assign game_over    = r_game_over;
   assign game_won     = r_game_won;

endmodule

// File: tb/tb_guess_entry_ctrl.sv
module tb_guess_entry_ctrl;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       start_game;
   logic       credit_ok;
   logic       key;
   logic [1:0] slot;
   logic       clear_game;
   logic       grade_done;
   logic       win;
   logic [3:0] load_en;
   logic [3:0] slot_loaded;
   logic       load_guess;
   logic       grade_req;
   logic       game_start;
   logic [3:0] round_number;
   logic       game_over;
   logic       game_won;

   int n_cmp = 0;
   int n_err = 0;

   guess_entry_ctrl #(.NUM_SLOTS(4), .SHAPE_W(3), .MAX_ROUNDS(8)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start_game   (start_game),
      .credit_ok    (credit_ok),
      .key          (key),
      .slot         (slot),
      .clear_game   (clear_game),
      .grade_done   (grade_done),
      .win          (win),
      .load_en      (load_en),
      .slot_loaded  (slot_loaded),
      .load_guess   (load_guess),
      .grade_req    (grade_req),
      .game_start   (game_start),
      .round_number (round_number),
      .game_over    (game_over),
      .game_won     (game_won)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".load_en"}, 32'(load_en), 0);
      chk({tag, ".slot_loaded"}, 32'(slot_loaded), 0);
      chk({tag, ".load_guess"}, 32'(load_guess), 0);
      chk({tag, ".grade_req"}, 32'(grade_req), 0);
      chk({tag, ".game_start"}, 32'(game_start), 0);
      chk({tag, ".round"}, 32'(round_number), 0);
      chk({tag, ".over"}, 32'(game_over), 0);
      chk({tag, ".won"}, 32'(game_won), 0);
   endtask

   // One key press in SETUP: strobe on the first cycle, gone on the second.
   task automatic press(input logic [1:0] s, input logic [3:0] exp_en,
                        input logic [3:0] exp_loaded, input logic exp_play);
      slot = s;
      key  = 1'b1;
      step();
      chk("press.load_en", 32'(load_en), 32'(exp_en));
      chk("press.slot_loaded", 32'(slot_loaded), 32'(exp_loaded));
      chk("press.grade_req", 32'(grade_req), 0);
      key = 1'b0;
      step();
      chk("press.load_en_off", 32'(load_en), 0);
      chk("press.play", 32'(load_guess), 32'(exp_play));
   endtask

   task automatic start_new();
      start_game = 1'b1;
      credit_ok  = 1'b1;
      step();
      chk("start.game_start", 32'(game_start), 1);
      chk("start.slot_loaded", 32'(slot_loaded), 0);
      chk("start.round", 32'(round_number), 0);
      chk("start.over", 32'(game_over), 0);
      chk("start.won", 32'(game_won), 0);
      start_game = 1'b0;
      step();
      chk("start.pulse_off", 32'(game_start), 0);
   endtask

   // One guess from PLAY, answered by the grader with verdict w.
   task automatic guess(input logic w, input logic [3:0] exp_round,
                        input logic exp_over, input logic exp_won);
      key = 1'b1;
      step();
      chk("guess.grade_req", 32'(grade_req), 1);
      chk("guess.round", 32'(round_number), 32'(exp_round));
      chk("guess.load_en", 32'(load_en), 0);
      key = 1'b0;
      step();
      chk("guess.grade_req_off", 32'(grade_req), 0);
      chk("guess.wait_no_guess", 32'(load_guess), 0);
      grade_done = 1'b1;
      win        = w;
      step();
      grade_done = 1'b0;
      win        = 1'b0;
      chk("guess.over", 32'(game_over), 32'(exp_over));
      chk("guess.won", 32'(game_won), 32'(exp_won));
      chk("guess.load_guess", 32'(load_guess), 32'(!exp_over));
      chk("guess.round_after", 32'(round_number), 32'(exp_round));
   endtask

   initial begin
      int pulses;
      reset_n    = 1'b0;
      start_game = 1'b0;
      credit_ok  = 1'b0;
      key        = 1'b1;
      slot       = 2'd0;
      clear_game = 1'b0;
      grade_done = 1'b0;
      win        = 1'b0;
      step();
      step();
      chk_all_zero("reset");

      // Release reset with key held; start a game straight away.
      reset_n = 1'b1;
      start_new();
      chk("held_key.no_load", 32'(load_en), 0);
      step();
      chk("held_key.no_load2", 32'(load_en), 0);
      chk("setup.no_play", 32'(load_guess), 0);
      key = 1'b0;
      step();

      press(2'd2, 4'b0100, 4'b0100, 1'b0);
      press(2'd0, 4'b0001, 4'b0101, 1'b0);
      press(2'd2, 4'b0100, 4'b0101, 1'b0);
      press(2'd3, 4'b1000, 4'b1101, 1'b0);
      press(2'd1, 4'b0010, 4'b1111, 1'b1);

      // Key held 10 cycles in PLAY: exactly one grade request.
      pulses = 0;
      key = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (grade_req) pulses++;
         chk("hold.load_guess", 32'(load_guess), 0);
      end
      key = 1'b0;
      chk("hold.pulses", 32'(pulses), 1);
      chk("hold.round", 32'(round_number), 1);
      grade_done = 1'b1;
      step();
      grade_done = 1'b0;
      chk("hold.back_to_play", 32'(load_guess), 1);
      chk("hold.not_over", 32'(game_over), 0);

      // Rounds 2..8 all lose; the 8th ends the game.
      for (int r = 2; r <= 8; r++) begin
         guess(1'b0, 4'(r), (r == 8), 1'b0);
      end
      key = 1'b1;
      step();
      chk("over.key_ignored", 32'(grade_req), 0);
      chk("over.round_max", 32'(round_number), 8);
      key = 1'b0;
      grade_done = 1'b1;
      win        = 1'b1;
      step();
      grade_done = 1'b0;
      win        = 1'b0;
      chk("over.grade_ignored", 32'(game_won), 0);
      chk("over.still_over", 32'(game_over), 1);

      // Second game from OVER; win on round 3.
      start_new();
      press(2'd0, 4'b0001, 4'b0001, 1'b0);
      press(2'd1, 4'b0010, 4'b0011, 1'b0);
      press(2'd2, 4'b0100, 4'b0111, 1'b0);
      press(2'd3, 4'b1000, 4'b1111, 1'b1);
      grade_done = 1'b1;
      win        = 1'b1;
      start_game = 1'b1;
      credit_ok  = 1'b1;
      step();
      grade_done = 1'b0;
      win        = 1'b0;
      start_game = 1'b0;
      chk("play.grade_ignored", 32'(game_won), 0);
      chk("play.start_ignored", 32'(game_start), 0);
      chk("play.still_play", 32'(load_guess), 1);
      guess(1'b0, 4'd1, 1'b0, 1'b0);
      guess(1'b0, 4'd2, 1'b0, 1'b0);
      guess(1'b1, 4'd3, 1'b1, 1'b1);
      start_game = 1'b1;
      credit_ok  = 1'b0;
      step();
      start_game = 1'b0;
      chk("nocredit.game_start", 32'(game_start), 0);
      chk("nocredit.won", 32'(game_won), 1);
      chk("nocredit.round", 32'(round_number), 3);

      // clear_game beats a simultaneous key edge in PLAY.
      start_new();
      press(2'd0, 4'b0001, 4'b0001, 1'b0);
      press(2'd1, 4'b0010, 4'b0011, 1'b0);
      press(2'd2, 4'b0100, 4'b0111, 1'b0);
      press(2'd3, 4'b1000, 4'b1111, 1'b1);
      guess(1'b0, 4'd1, 1'b0, 1'b0);
      clear_game = 1'b1;
      key        = 1'b1;
      step();
      clear_game = 1'b0;
      chk_all_zero("clear");
      key = 1'b0;
      step();
      key = 1'b1;
      step();
      chk("idle.key_ignored", 32'(grade_req), 0);
      key = 1'b0;

      // Asynchronous reset mid-SETUP, released with key held.
      start_new();
      press(2'd1, 4'b0010, 4'b0010, 1'b0);
      key = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("areset.slot_loaded", 32'(slot_loaded), 0);
      chk("areset.load_en", 32'(load_en), 0);
      step();
      reset_n = 1'b1;
      start_game = 1'b1;
      credit_ok  = 1'b1;
      step();
      start_game = 1'b0;
      chk("areset.restart", 32'(game_start), 1);
      step();
      chk("areset.no_load", 32'(load_en), 0);
      chk("areset.no_flags", 32'(slot_loaded), 0);
      key = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/guess_entry_ctrl.md
GUESS_ENTRY_CTRL -- requirements
Module: guess_entry_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SLOTS, default 4: number of pattern slots (2..8).
REQ-002 The block SHALL have parameter SHAPE_W, default 3: shape code width.
REQ-003 The block SHALL have parameter MAX_ROUNDS, default 8: guesses per game (1..15).
REQ-004 The block SHALL have localparams SLOT_W = clog2(NUM_SLOTS) and RND_W = clog2(MAX_ROUNDS+1).
REQ-005 The block SHALL have port clock  in  1: single clock; all state on its rising edge.
REQ-006 The block SHALL have port reset_n  in  1: reset, asynchronous, active-low.
REQ-007 The block SHALL have port start_game  in  1: synchronized start request, level.
REQ-008 The block SHALL have port credit_ok  in  1: at least one paid game available.
REQ-009 The block SHALL have port key  in  1: synchronized action button, level, high = pressed.
REQ-010 The block SHALL have port slot  in  SLOT_W: target slot for master-shape load.
REQ-011 The block SHALL have port clear_game  in  1: synchronous abort to IDLE.
REQ-012 The block SHALL have port grade_done  in  1: grader result valid, one-cycle pulse.
REQ-013 The block SHALL have port win  in  1: grader verdict, qualified by grade_done.
REQ-014 The block SHALL have port load_en  out  NUM_SLOTS: one-hot master-slot write strobe.
REQ-015 The block SHALL have port slot_loaded  out  NUM_SLOTS: per-slot loaded flags.
REQ-016 The block SHALL have port load_guess  out  1: high while guesses are accepted.
REQ-017 The block SHALL have port grade_req  out  1: one-cycle grade request pulse.
REQ-018 The block SHALL have port game_start  out  1: one-cycle pulse consuming one credit.
REQ-019 The block SHALL have port round_number  out  RND_W: guesses submitted this game.
REQ-020 The block SHALL have ports game_over and game_won  out  1 each: end-of-game flags.

Function
REQ-021 The block SHALL generate key_edge = key & ~key_q, where key_q is key registered; every action SHALL use key_edge only, never the key level.
REQ-022 The block SHALL implement FSM states IDLE, SETUP, PLAY, GRADE_WAIT and OVER.
REQ-023 In IDLE or OVER, when start_game & credit_ok, the block SHALL go to SETUP, pulse game_start next cycle, and clear slot_loaded, round_number, game_over and game_won.
REQ-024 In SETUP, on key_edge with slot < NUM_SLOTS, the block SHALL assert load_en[slot] for exactly the next cycle and set slot_loaded[slot]; re-loading a slot is allowed.
REQ-025 In SETUP, on key_edge with slot >= NUM_SLOTS, the block SHALL produce no strobe and no flag change.
REQ-026 The block SHALL go from SETUP to PLAY on the cycle after slot_loaded becomes all-ones.
REQ-027 In PLAY, load_guess SHALL be 1; on key_edge the block SHALL pulse grade_req for one cycle (registered, t+1), increment round_number in the same cycle, and go to GRADE_WAIT.
REQ-028 In GRADE_WAIT, key_edge SHALL be ignored and load_guess SHALL be 0.
REQ-029 In GRADE_WAIT, on grade_done with win=1, the block SHALL set game_won and game_over and go to OVER.
REQ-030 In GRADE_WAIT, on grade_done with win=0 and round_number == MAX_ROUNDS, the block SHALL set game_over and go to OVER.
REQ-031 In GRADE_WAIT, on grade_done with win=0 and round_number < MAX_ROUNDS, the block SHALL return to PLAY.
REQ-032 grade_done outside GRADE_WAIT SHALL be ignored.
REQ-033 round_number SHALL never exceed MAX_ROUNDS and SHALL never wrap.
REQ-034 clear_game SHALL have priority over all other inputs: the block SHALL go to IDLE and clear all outputs and flags next cycle.
REQ-035 start_game in SETUP, PLAY or GRADE_WAIT SHALL be ignored.
REQ-036 start_game with credit_ok=0 SHALL be ignored.
REQ-037 load_en and grade_req SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per key_edge.

Reset
REQ-038 On reset_n=0 the block SHALL be in IDLE with load_en=0, slot_loaded=0, load_guess=0, grade_req=0, game_start=0, round_number=0, game_over=0 and game_won=0.
REQ-039 key_q SHALL reset to 1 so that a key held through reset release produces no key_edge.
REQ-040 reset_n asserted mid-game (any state) SHALL return the block to IDLE immediately, with no pending strobe emitted after release.

Verification
REQ-041 Bench SHALL cover: start_game=1, credit_ok=1 in IDLE -> game_start pulse 1 cycle, state SETUP, slot_loaded=0000.
REQ-042 Bench SHALL cover: key edges with slot=2,0,2,3,1 -> load_en 0100,0001,0100,1000,0010, each high 1 cycle; PLAY entered 1 cycle after slot_loaded=1111.
REQ-043 Bench SHALL cover: key held high for 10 cycles in PLAY -> exactly one grade_req pulse, round_number 0->1, load_guess 0 until grade_done.
REQ-044 Bench SHALL cover: MAX_ROUNDS=8, 8 guesses each answered grade_done=1, win=0 -> game_over=1, game_won=0, round_number=8, further key edges ignored.
REQ-045 Bench SHALL cover: grade_done=1, win=1 on round 3 -> game_won=1, game_over=1, round_number=3; then start_game with credit_ok=0 -> no change.
REQ-046 Bench SHALL cover: clear_game and key_edge in the same cycle in PLAY -> no grade_req, IDLE next cycle, all outputs 0; key held across reset_n release -> no load_en.
